// File: rtl/host_wire_queue_bridge.sv
// host_wire_queue_bridge
// Buffers host wire-in traffic toward the emulator core and core results back toward
// host wire-out endpoints. Host-side wires are level signals; their rising edges act as
// push (h2d_valid_wire) and pop (d2h_ack_wire) strobes.
//
// Ports
//   clock, reset     single clock, synchronous active-high reset
//   h2d_bits         host payload, sampled on the h2d_valid_wire rising edge
//   h2d_valid_wire   host push level
//   h2d_enq_ready    host->device FIFO not full
//   h2d_count        host->device occupancy
//   h2d_drop_cnt     saturating count of pushes rejected while full
//   deq_valid/ready/bits   valid/ready head of the host->device FIFO toward the core
//   d2h_valid/ready/bits   valid/ready input from the core into the device->host FIFO
//   d2h_head_valid   device->host FIFO non-empty
//   d2h_head_bits    device->host FIFO head
//   d2h_ack_wire     host pop level
//   d2h_count        device->host occupancy
module host_wire_queue_bridge #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned IN_WORDS  = 2,
    parameter int unsigned OUT_WORDS = 1,
    parameter int unsigned IN_DEPTH  = 8,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [IN_WORDS*WORD_W-1:0]        h2d_bits,
    input  logic                              h2d_valid_wire,
    output logic                              h2d_enq_ready,
    output logic [$clog2(IN_DEPTH+1)-1:0]     h2d_count,
    output logic [15:0]                       h2d_drop_cnt,
    output logic                              deq_valid,
    input  logic                              deq_ready,
    output logic [IN_WORDS*WORD_W-1:0]        deq_bits,
    input  logic                              d2h_valid,
    output logic                              d2h_ready,
    input  logic [OUT_WORDS*WORD_W-1:0]       d2h_bits,
    output logic                              d2h_head_valid,
    output logic [OUT_WORDS*WORD_W-1:0]       d2h_head_bits,
    input  logic                              d2h_ack_wire,
    output logic [$clog2(OUT_DEPTH+1)-1:0]    d2h_count
);

    localparam int unsigned IN_W      = IN_WORDS * WORD_W;
    localparam int unsigned OUT_W     = OUT_WORDS * WORD_W;
    localparam int unsigned IN_PTR_W  = $clog2(IN_DEPTH);
    localparam int unsigned OUT_PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned IN_CNT_W  = $clog2(IN_DEPTH + 1);
    localparam int unsigned OUT_CNT_W = $clog2(OUT_DEPTH + 1);

    // Storage and pointer state
    logic [IN_W-1:0]      h2d_mem [IN_DEPTH];
    logic [OUT_W-1:0]     d2h_mem [OUT_DEPTH];
    logic [IN_PTR_W-1:0]  h2d_wr_ptr, h2d_rd_ptr;
    logic [OUT_PTR_W-1:0] d2h_wr_ptr, d2h_rd_ptr;
    logic [IN_CNT_W-1:0]  h2d_cnt_q, h2d_cnt_d;
    logic [OUT_CNT_W-1:0] d2h_cnt_q, d2h_cnt_d;
    logic [15:0]          drop_q, drop_d;
    logic                 prev_valid, prev_ack;

    // Event strobes
    logic push_req, push_ok, push_drop, deq_fire;
    logic pop_req, pop_fire, enq_fire;
    logic h2d_full, d2h_full;

    // Status outputs are decoded straight from the occupancy registers
    assign h2d_full       = (h2d_cnt_q == IN_CNT_W'(IN_DEPTH));
    assign d2h_full       = (d2h_cnt_q == OUT_CNT_W'(OUT_DEPTH));
    assign h2d_enq_ready  = ~h2d_full;
    assign h2d_count      = h2d_cnt_q;
    assign h2d_drop_cnt   = drop_q;
    assign deq_valid      = (h2d_cnt_q != '0);
    assign deq_bits       = h2d_mem[h2d_rd_ptr];
    assign d2h_ready      = ~d2h_full;
    assign d2h_head_valid = (d2h_cnt_q != '0);
    assign d2h_head_bits  = d2h_mem[d2h_rd_ptr];
    assign d2h_count      = d2h_cnt_q;

    // Edge detection, accept/drop decisions and next occupancy
    always_comb begin
        push_req  = h2d_valid_wire & ~prev_valid;
        deq_fire  = deq_valid & deq_ready;
        // A dequeue in the same cycle frees the slot the push will reuse
        push_ok   = push_req & (~h2d_full | deq_fire);
        push_drop = push_req & ~push_ok;
        pop_req   = d2h_ack_wire & ~prev_ack;
        pop_fire  = pop_req & d2h_head_valid;
        enq_fire  = d2h_valid & d2h_ready;

        h2d_cnt_d = h2d_cnt_q;
        if (push_ok && !deq_fire) begin
            h2d_cnt_d = h2d_cnt_q + IN_CNT_W'(1);
        end else if (!push_ok && deq_fire) begin
            h2d_cnt_d = h2d_cnt_q - IN_CNT_W'(1);
        end

        d2h_cnt_d = d2h_cnt_q;
        if (enq_fire && !pop_fire) begin
            d2h_cnt_d = d2h_cnt_q + OUT_CNT_W'(1);
        end else if (!enq_fire && pop_fire) begin
            d2h_cnt_d = d2h_cnt_q - OUT_CNT_W'(1);
        end

        drop_d = drop_q;
        if (push_drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Control state
    always_ff @(posedge clock) begin
        if (reset) begin
            h2d_wr_ptr <= '0;
            h2d_rd_ptr <= '0;
            d2h_wr_ptr <= '0;
            d2h_rd_ptr <= '0;
            h2d_cnt_q  <= '0;
            d2h_cnt_q  <= '0;
            drop_q     <= '0;
            // Held-high wires through reset must fall before they count again
            prev_valid <= 1'b1;
            prev_ack   <= 1'b1;
        end else begin
            if (push_ok)  h2d_wr_ptr <= h2d_wr_ptr + IN_PTR_W'(1);
            if (deq_fire) h2d_rd_ptr <= h2d_rd_ptr + IN_PTR_W'(1);
            if (enq_fire) d2h_wr_ptr <= d2h_wr_ptr + OUT_PTR_W'(1);
            if (pop_fire) d2h_rd_ptr <= d2h_rd_ptr + OUT_PTR_W'(1);
            h2d_cnt_q  <= h2d_cnt_d;
            d2h_cnt_q  <= d2h_cnt_d;
            drop_q     <= drop_d;
            prev_valid <= h2d_valid_wire;
            prev_ack   <= d2h_ack_wire;
        end
    end

    // Payload storage; contents are don't-care until counted valid
    always_ff @(posedge clock) begin
        if (!reset && push_ok) h2d_mem[h2d_wr_ptr] <= h2d_bits;
        if (!reset && enq_fire) d2h_mem[d2h_wr_ptr] <= d2h_bits;
    end

endmodule

// File: tb/tb_host_wire_queue_bridge.sv
// Self-checking bench for host_wire_queue_bridge: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_host_wire_queue_bridge;

    localparam int unsigned DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] h2d_bits;
    logic        h2d_valid_wire;
    logic        h2d_enq_ready;
    logic [3:0]  h2d_count;
    logic [15:0] h2d_drop_cnt;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_bits;
    logic        d2h_valid;
    logic        d2h_ready;
    logic [31:0] d2h_bits;
    logic        d2h_head_valid;
    logic [31:0] d2h_head_bits;
    logic        d2h_ack_wire;
    logic [3:0]  d2h_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] hq[$];
    logic [31:0] dq[$];
    bit          m_prev_valid = 1'b1;
    bit          m_prev_ack   = 1'b1;
    int          m_drop       = 0;

    always #5 clock = ~clock;

    host_wire_queue_bridge dut (
        .clock          (clock),
        .reset          (reset),
        .h2d_bits       (h2d_bits),
        .h2d_valid_wire (h2d_valid_wire),
        .h2d_enq_ready  (h2d_enq_ready),
        .h2d_count      (h2d_count),
        .h2d_drop_cnt   (h2d_drop_cnt),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_bits       (deq_bits),
        .d2h_valid      (d2h_valid),
        .d2h_ready      (d2h_ready),
        .d2h_bits       (d2h_bits),
        .d2h_head_valid (d2h_head_valid),
        .d2h_head_bits  (d2h_head_bits),
        .d2h_ack_wire   (d2h_ack_wire),
        .d2h_count      (d2h_count)
    );

    // Advance one clock and apply the same cycle to the model (inputs are stable across the edge)
    task automatic tick();
        bit          rst, dfire, preq, enq, pop;
        logic [63:0] pb;
        logic [31:0] db;
        rst   = reset;
        dfire = (hq.size() > 0) && deq_ready;
        preq  = h2d_valid_wire && !m_prev_valid;
        enq   = d2h_valid && (dq.size() < DEPTH);
        pop   = d2h_ack_wire && !m_prev_ack && (dq.size() > 0);
        pb    = h2d_bits;
        db    = d2h_bits;
        @(posedge clock);
        #1;
        if (rst) begin
            hq.delete();
            dq.delete();
            m_prev_valid = 1'b1;
            m_prev_ack   = 1'b1;
            m_drop       = 0;
        end else begin
            if (dfire) void'(hq.pop_front());
            if (preq) begin
                if (hq.size() < DEPTH) hq.push_back(pb);
                else if (m_drop < 16'hFFFF) m_drop++;
            end
            if (pop) void'(dq.pop_front());
            if (enq) dq.push_back(db);
            m_prev_valid = h2d_valid_wire;
            m_prev_ack   = d2h_ack_wire;
        end
    endtask

    task automatic push_entry(input logic [63:0] b);
        h2d_valid_wire = 1'b0;
        tick();
        h2d_bits       = b;
        h2d_valid_wire = 1'b1;
        tick();
        h2d_valid_wire = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; h2d_valid_wire = 1'b1; d2h_ack_wire = 1'b1;
        deq_ready = 1'b0; d2h_valid = 1'b0; h2d_bits = 64'hDEAD; d2h_bits = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (h2d_count !== 4'd0 || deq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_wire: count=%0d deq_valid=%b expected 0/0", h2d_count, deq_valid);
        end
        n_tests++;
        if ({h2d_enq_ready, d2h_ready, d2h_head_valid, d2h_count, h2d_drop_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: enq_ready=%b d2h_ready=%b head_valid=%b d2h_count=%0d drop=%0d expected 1 1 0 0 0",
                     h2d_enq_ready, d2h_ready, d2h_head_valid, d2h_count, h2d_drop_cnt);
        end
        h2d_valid_wire = 1'b0; d2h_ack_wire = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        push_entry({32'h80, 32'h01});
        n_tests++;
        if (deq_valid !== 1'b1 || deq_bits !== 64'h80_00000001 || h2d_count !== 4'd1) begin
            n_fail++;
            $display("FAIL single_push: valid=%b bits=%h count=%0d expected 1 0000008000000001 1", deq_valid, deq_bits, h2d_count);
        end
        deq_ready = 1'b1; tick(); deq_ready = 1'b0;
        n_tests++;
        if (deq_valid !== 1'b0 || h2d_count !== 4'd0) begin
            n_fail++;
            $display("FAIL single_drain: valid=%b count=%0d expected 0 0", deq_valid, h2d_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) push_entry(64'(i));
        tick();
        n_tests++;
        if (h2d_count !== 4'd8 || h2d_enq_ready !== 1'b0 || h2d_drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow: count=%0d enq_ready=%b drop=%0d expected 8 0 2", h2d_count, h2d_enq_ready, h2d_drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (deq_valid !== 1'b1 || deq_bits !== 64'(i)) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: valid=%b bits=%h expected 1 %h", i, deq_valid, deq_bits, 64'(i));
            end
            deq_ready = 1'b1; tick(); deq_ready = 1'b0;
        end
        n_tests++;
        if (deq_valid !== 1'b0 || h2d_count !== 4'd0) begin
            n_fail++;
            $display("FAIL overflow_empty: valid=%b count=%0d expected 0 0", deq_valid, h2d_count);
        end
    endtask

    task automatic test_full_push_deq();
        logic [63:0] exp_seq [8];
        for (int i = 0; i < 8; i++) push_entry(64'(100 + i));
        tick();
        h2d_bits = 64'd200; h2d_valid_wire = 1'b1; deq_ready = 1'b1;
        tick();
        h2d_valid_wire = 1'b0; deq_ready = 1'b0;
        n_tests++;
        if (h2d_count !== 4'd8 || h2d_drop_cnt !== 16'd2 || deq_bits !== 64'd101) begin
            n_fail++;
            $display("FAIL full_push_deq: count=%0d drop=%0d head=%0d expected 8 2 101", h2d_count, h2d_drop_cnt, deq_bits);
        end
        for (int i = 0; i < 7; i++) exp_seq[i] = 64'(101 + i);
        exp_seq[7] = 64'd200;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (deq_valid !== 1'b1 || deq_bits !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: valid=%b bits=%0d expected 1 %0d", i, deq_valid, deq_bits, exp_seq[i]);
            end
            deq_ready = 1'b1; tick(); deq_ready = 1'b0;
        end
    endtask

    task automatic test_return();
        logic [31:0] heads [3];
        heads[0] = 32'h4; heads[1] = 32'h8; heads[2] = 32'h9;
        d2h_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d2h_bits = heads[i];
            tick();
        end
        d2h_valid = 1'b0;
        n_tests++;
        if (d2h_count !== 4'd3) begin
            n_fail++;
            $display("FAIL return_count: got %0d expected 3", d2h_count);
        end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                n_tests++;
                if (d2h_head_valid !== 1'b1 || d2h_head_bits !== heads[k]) begin
                    n_fail++;
                    $display("FAIL return_head[%0d]: valid=%b bits=%h expected 1 %h", k, d2h_head_valid, d2h_head_bits, heads[k]);
                end
            end
            d2h_ack_wire = 1'b1; tick();
            d2h_ack_wire = 1'b0; tick();
        end
        n_tests++;
        if (d2h_head_valid !== 1'b0 || d2h_count !== 4'd0) begin
            n_fail++;
            $display("FAIL return_extra_ack: head_valid=%b count=%0d expected 0 0", d2h_head_valid, d2h_count);
        end
    endtask

    task automatic test_return_full_and_reset();
        d2h_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d2h_bits = 32'(16 + i);
            tick();
        end
        n_tests++;
        if (d2h_ready !== 1'b0 || d2h_count !== 4'd8 || d2h_head_bits !== 32'd16) begin
            n_fail++;
            $display("FAIL return_full: ready=%b count=%0d head=%0d expected 0 8 16", d2h_ready, d2h_count, d2h_head_bits);
        end
        d2h_ack_wire = 1'b1;
        tick();
        n_tests++;
        if (d2h_ready !== 1'b1 || d2h_head_bits !== 32'd17) begin
            n_fail++;
            $display("FAIL return_pop_ready: ready=%b head=%0d expected 1 17", d2h_ready, d2h_head_bits);
        end
        d2h_ack_wire = 1'b0;
        push_entry(64'hAA);
        push_entry(64'hBB);
        reset = 1'b1;
        tick();
        n_tests++;
        if ({h2d_count, d2h_count, deq_valid, d2h_head_valid, h2d_drop_cnt, h2d_enq_ready, d2h_ready}
            !== {4'd0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset: h2d_count=%0d d2h_count=%0d deq_valid=%b head_valid=%b drop=%0d expected 0 0 0 0 0",
                     h2d_count, d2h_count, deq_valid, d2h_head_valid, h2d_drop_cnt);
        end
        reset = 1'b0; d2h_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [127:0] act, exp;
        int           fails_here;
        fails_here = 0;
        for (int c = 0; c < 1500; c++) begin
            int rdy_bias;
            rdy_bias = ((c / 250) % 2 == 0) ? 1 : 3;
            if ($urandom_range(0, 2) == 0) h2d_valid_wire = ~h2d_valid_wire;
            if ($urandom_range(0, 2) == 0) d2h_ack_wire   = ~d2h_ack_wire;
            h2d_bits  = {$urandom, $urandom};
            d2h_bits  = $urandom;
            deq_ready = ($urandom_range(0, 3) < rdy_bias);
            d2h_valid = ($urandom_range(0, 3) >= rdy_bias);
            reset     = ($urandom_range(0, 399) == 0);
            tick();
            act = {h2d_enq_ready, h2d_count, h2d_drop_cnt, deq_valid, d2h_ready, d2h_head_valid, d2h_count,
                   (deq_valid ? deq_bits : 64'd0), (d2h_head_valid ? d2h_head_bits : 32'd0)};
            exp = {(hq.size() < DEPTH), 4'(hq.size()), 16'(m_drop), (hq.size() > 0), (dq.size() < DEPTH),
                   (dq.size() > 0), 4'(dq.size()),
                   (hq.size() > 0 ? hq[0] : 64'd0), (dq.size() > 0 ? dq[0] : 32'd0)};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                fails_here++;
                if (fails_here <= 10)
                    $display("FAIL random[%0d]: got %h expected %h", c, act, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_overflow();
        test_full_push_deq();
        test_return();
        test_return_full_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
